// File: rtl/board_pkg.sv
// Shared constants, tile/state encodings and address helpers for the board line fetcher.
package board_pkg;

   localparam int COLS   = 10;
   localparam int ROWS   = 10;
   localparam int TILE_H = 16;
   localparam int TILE_W = 32;

   localparam logic [3:0] LAST_COL = 4'(COLS - 1);
   localparam logic [7:0] Y_LIMIT  = 8'(ROWS * TILE_H);
   localparam logic [8:0] X_LIMIT  = 9'(COLS * TILE_W);

   typedef enum logic [1:0] {
      SHIP  = 2'd0,
      EMPTY = 2'd1,
      HIT   = 2'd2,
      MISS  = 2'd3
   } tile_t;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_DRAIN = 2'd2
   } fetch_state_t;

   function automatic logic [6:0] cell_index(input logic [3:0] row, input logic [3:0] col);
      return ({3'b000, row} * 7'(COLS)) + {3'b000, col};
   endfunction

   // ROM line address: tile code in the top bits, bit 4 unused, pixel line in the low nibble.
   function automatic logic [6:0] rom_line_addr(input tile_t tile, input logic [3:0] line);
      return {tile, 1'b0, line};
   endfunction

endpackage

// File: rtl/board_line_bank.sv
// Ping-pong line buffer: two banks of COLS tile lines, one write port, one registered pixel read.
module board_line_bank
   import board_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic              wr_bank,
   input  logic [3:0]        wr_col,
   input  logic [TILE_W-1:0] wr_data,
   input  logic              rd_bank,
   input  logic [8:0]        px_x,
   output logic              px_on
);

   logic [TILE_W-1:0] mem [2][COLS];
   logic [3:0]        rd_col;
   logic [4:0]        rd_bit;

   // Bit 31 of a tile line is its leftmost pixel.
   assign rd_col = px_x[8:5];
   assign rd_bit = 5'd31 - px_x[4:0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int b = 0; b < 2; b++) begin
            for (int c = 0; c < COLS; c++) begin
               mem[b][c] <= '0;
            end
         end
         px_on <= 1'b0;
      end else begin
         if (wr_en) begin
            mem[wr_bank][wr_col] <= wr_data;
         end
         px_on <= (px_x < X_LIMIT) ? mem[rd_bank][rd_col][rd_bit] : 1'b0;
      end
   end

endmodule

// File: rtl/board_line_fetch.sv
// Fetches one board pixel line of tile data into the back bank during hblank and
// serves pixels from the front bank; front/back exchange on swap.
module board_line_fetch
   import board_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        fetch_start,
   input  logic [7:0]  fetch_y,
   output logic        busy,
   output logic        fetch_done,
   output logic        cell_rd_en,
   output logic [6:0]  cell_addr,
   input  logic [1:0]  cell_state,
   output logic [6:0]  rom_addr,
   input  logic [31:0] rom_data,
   input  logic        swap,
   input  logic [8:0]  px_x,
   output logic        px_on
);

   fetch_state_t      state, state_nxt;
   logic [3:0]        col, col_nxt;
   logic              oor;
   logic              front;
   logic              swap_pend;
   logic              swap_apply;
   logic              start_ok;
   logic [3:0]        row, line;

   logic              vld_p0, vld_p1, vld_p2;
   logic [3:0]        col_p1, col_p2;
   logic              zero_p1, zero_p2;
   logic [TILE_W-1:0] wr_data;

   assign start_ok   = (state == S_IDLE) && fetch_start;
   assign busy       = (state != S_IDLE);
   assign vld_p0     = (state == S_FETCH);
   assign cell_rd_en = vld_p0 && !oor;
   assign cell_addr  = cell_rd_en ? cell_index(row, col) : 7'd0;

   // Stage p1: cell_state has returned; it becomes the ROM line address.
   assign rom_addr   = (vld_p1 && !zero_p1) ? rom_line_addr(tile_t'(cell_state), line) : 7'd0;

   // Stage p2: ROM data lands in the back bank; the last column marks completion.
   assign fetch_done = vld_p2 && (col_p2 == LAST_COL);
   assign wr_data    = zero_p2 ? '0 : rom_data;

   // A swap during a fetch is held back so the front bank never changes mid-fill.
   assign swap_apply = busy ? (fetch_done && (swap_pend || swap)) : swap;

   always_comb begin
      state_nxt = state;
      col_nxt   = col;
      unique case (state)
         S_IDLE: begin
            if (fetch_start) begin
               state_nxt = S_FETCH;
               col_nxt   = 4'd0;
            end
         end
         S_FETCH: begin
            if (col == LAST_COL) begin
               state_nxt = S_DRAIN;
            end else begin
               col_nxt = col + 4'd1;
            end
         end
         S_DRAIN: begin
            if (fetch_done) begin
               state_nxt = S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         col       <= 4'd0;
         oor       <= 1'b0;
         front     <= 1'b0;
         swap_pend <= 1'b0;
         vld_p1    <= 1'b0;
         vld_p2    <= 1'b0;
      end else begin
         state  <= state_nxt;
         col    <= col_nxt;
         vld_p1 <= vld_p0;
         vld_p2 <= vld_p1;
         front  <= front ^ swap_apply;
         if (start_ok) begin
            oor <= (fetch_y >= Y_LIMIT);
         end
         if (!busy || fetch_done) begin
            swap_pend <= 1'b0;
         end else if (swap) begin
            swap_pend <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (start_ok) begin
         row  <= fetch_y[7:4];
         line <= fetch_y[3:0];
      end
      col_p1  <= col;
      col_p2  <= col_p1;
      zero_p1 <= oor;
      zero_p2 <= zero_p1;
   end

   board_line_bank u_bank (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (vld_p2),
      .wr_bank (~front),
      .wr_col  (col_p2),
      .wr_data (wr_data),
      .rd_bank (front),
      .px_x    (px_x),
      .px_on   (px_on)
   );

endmodule

// File: tb/tb_board_line_fetch.sv
// Self-checking bench for board_line_fetch with board-memory and tile-ROM responders.
module tb_board_line_fetch;

   logic        clk = 1'b0;
   logic        rst;
   logic        fetch_start;
   logic [7:0]  fetch_y;
   logic        busy;
   logic        fetch_done;
   logic        cell_rd_en;
   logic [6:0]  cell_addr;
   logic [1:0]  cell_state = 2'd0;
   logic [6:0]  rom_addr;
   logic [31:0] rom_data = 32'd0;
   logic        swap;
   logic [8:0]  px_x;
   logic        px_on;

   int vectors     = 0;
   int miscompares = 0;

   logic [1:0]  board   [100];
   logic [31:0] rom_mem [128];
   logic [31:0] model_bank [2][10];
   bit          model_front;
   bit          model_pend;

   board_line_fetch dut (
      .clk         (clk),
      .rst         (rst),
      .fetch_start (fetch_start),
      .fetch_y     (fetch_y),
      .busy        (busy),
      .fetch_done  (fetch_done),
      .cell_rd_en  (cell_rd_en),
      .cell_addr   (cell_addr),
      .cell_state  (cell_state),
      .rom_addr    (rom_addr),
      .rom_data    (rom_data),
      .swap        (swap),
      .px_x        (px_x),
      .px_on       (px_on)
   );

   always #5 clk = ~clk;

   // Board-state memory and tile ROM, each with one cycle of read latency.
   always @(posedge clk) begin
      if (cell_rd_en) cell_state <= board[cell_addr];
      rom_data <= rom_mem[rom_addr];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic px_ref(input logic [8:0] p);
      int pi;
      pi = int'(p);
      if (pi >= 320) return 1'b0;
      return model_bank[model_front][pi / 32][31 - (pi % 32)];
   endfunction

   // One clock; the pixel read issued this cycle is checked on the following cycle.
   task automatic tick();
      logic e;
      e = px_ref(px_x);
      @(posedge clk);
      #1;
      chk("px_on", px_on, e);
   endtask

   function automatic logic [8:0] rand_px();
      if ($urandom_range(0, 7) == 0) return 9'($urandom_range(320, 511));
      return 9'($urandom_range(0, 319));
   endfunction

   task automatic swap_idle();
      swap = 1'b1;
      tick();
      swap = 1'b0;
      model_front = ~model_front;
   endtask

   task automatic scan_all();
      for (int p = 0; p <= 320; p++) begin
         px_x = 9'(p);
         tick();
      end
      px_x = 9'd511;
      tick();
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, fetch_done, 0);
      chk({tag, "_rd_en"}, cell_rd_en, 0);
      chk({tag, "_cell_addr"}, cell_addr, 0);
      chk({tag, "_rom_addr"}, rom_addr, 0);
      chk({tag, "_px_on"}, px_on, 0);
   endtask

   // Issues a fetch and checks the whole 12-cycle schedule against the line the
   // board/ROM contents imply. Optional swaps and a second fetch_start land mid-fetch.
   task automatic run_fetch(input logic [7:0] y, input int swap_at, input int restart_at,
                            input bit swap_with_start);
      logic [31:0] exp_line [10];
      logic [1:0]  tiles [10];
      int          row, ln;
      bit          oor;
      bit          back;
      row = int'(y[7:4]);
      ln  = int'(y[3:0]);
      oor = (int'(y) >= 160);
      for (int c = 0; c < 10; c++) begin
         tiles[c]    = oor ? 2'd0 : board[row * 10 + c];
         exp_line[c] = oor ? 32'd0 : rom_mem[{tiles[c], 1'b0, 4'(ln)}];
      end
      fetch_start = 1'b1;
      fetch_y     = y;
      swap        = swap_with_start;
      px_x        = rand_px();
      tick();
      fetch_start = 1'b0;
      swap        = 1'b0;
      if (swap_with_start) model_front = ~model_front;
      back = ~model_front;
      for (int i = 1; i <= 12; i++) begin
         chk("busy", busy, 1);
         chk("cell_rd_en", cell_rd_en, (!oor && i <= 10) ? 1 : 0);
         if (!oor && i <= 10) chk("cell_addr", cell_addr, row * 10 + i - 1);
         if (!oor && i >= 2 && i <= 11)
            chk("rom_addr", rom_addr, {25'd0, tiles[i - 2], 1'b0, 4'(ln)});
         chk("fetch_done", fetch_done, (i == 12) ? 1 : 0);
         swap        = (swap_at != 0) && (i == swap_at || i == swap_at + 2);
         fetch_start = (i == restart_at);
         fetch_y     = 8'($urandom_range(0, 255));
         px_x        = rand_px();
         if (swap) model_pend = 1'b1;
         tick();
         swap        = 1'b0;
         fetch_start = 1'b0;
         if (i == 12) begin
            for (int c = 0; c < 10; c++) model_bank[back][c] = exp_line[c];
            if (model_pend) model_front = ~model_front;
            model_pend = 1'b0;
         end
      end
      for (int i = 0; i < 3; i++) begin
         chk("idle_busy", busy, 0);
         chk("idle_done", fetch_done, 0);
         px_x = rand_px();
         tick();
      end
   endtask

   initial begin
      rst         = 1'b1;
      fetch_start = 1'b0;
      fetch_y     = 8'd0;
      swap        = 1'b0;
      px_x        = 9'd0;
      model_front = 1'b0;
      model_pend  = 1'b0;
      for (int i = 0; i < 100; i++) board[i] = 2'($urandom_range(0, 3));
      for (int i = 0; i < 128; i++) rom_mem[i] = $urandom;
      for (int b = 0; b < 2; b++) for (int c = 0; c < 10; c++) model_bank[b][c] = 32'd0;

      repeat (2) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      rst = 1'b0;
      tick();
      tick();

      // Row 2 line 3, all SHIP.
      for (int c = 0; c < 10; c++) board[20 + c] = 2'd0;
      rom_mem[7'h03] = 32'hFFFF_FFFF;
      run_fetch(8'h23, 0, 0, 0);
      swap_idle();
      scan_all();

      // Row 4 line 6, alternating HIT/MISS.
      for (int c = 0; c < 10; c++) board[40 + c] = (c % 2 == 0) ? 2'd2 : 2'd3;
      rom_mem[7'h46] = 32'h001C_3800;
      rom_mem[7'h66] = 32'h7000_000E;
      run_fetch(8'h46, 0, 0, 0);
      swap_idle();
      px_x = 9'd7;
      tick();
      px_x = 9'd43;
      tick();
      scan_all();

      // Out-of-range line fills zeros.
      run_fetch(8'd200, 0, 0, 0);
      swap_idle();
      scan_all();

      // Swap and a second start while busy.
      run_fetch(8'($urandom_range(0, 159)), 5, 5, 0);
      scan_all();

      // Swap coinciding with start in idle.
      run_fetch(8'($urandom_range(0, 159)), 0, 0, 1);
      scan_all();
      swap_idle();
      scan_all();

      // Reset in the middle of a fetch.
      fetch_start = 1'b1;
      fetch_y     = 8'($urandom_range(0, 159));
      tick();
      fetch_start = 1'b0;
      repeat (5) begin
         px_x = rand_px();
         tick();
      end
      rst = 1'b1;
      #1;
      check_reset_outputs("midrst");
      model_front = 1'b0;
      model_pend  = 1'b0;
      for (int b = 0; b < 2; b++) for (int c = 0; c < 10; c++) model_bank[b][c] = 32'd0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      for (int i = 0; i < 14; i++) begin
         chk("post_rst_done", fetch_done, 0);
         chk("post_rst_busy", busy, 0);
         px_x = rand_px();
         tick();
      end
      swap_idle();
      scan_all();
      run_fetch(8'($urandom_range(0, 159)), 0, 0, 0);
      swap_idle();
      scan_all();

      // Randomized fetches.
      for (int n = 0; n < 24; n++) begin
         for (int i = 0; i < 100; i++) board[i] = 2'($urandom_range(0, 3));
         run_fetch(8'($urandom_range(0, 255)),
                   ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 10)),
                   ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 12)),
                   ($urandom_range(0, 3) == 0));
         if ($urandom_range(0, 1) == 1) swap_idle();
         for (int k = 0; k < 40; k++) begin
            px_x = rand_px();
            tick();
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
